// File: rtl/game_sequencer.sv
// Round/phase controller for the duck hunt display pipeline.
// Ports: Clk, Reset_n (async, active low), frame_tick, start_btn, shot,
//   hit, duck_escaped in; state, shot_flash, num_shots, ducks_left,
//   hits, score_bcd out (all registered).
module game_sequencer #(
    parameter int unsigned SHOTS_PER_DUCK = 3,
    parameter int unsigned DUCKS_PER_GAME = 10,
    parameter int unsigned INTRO_FRAMES   = 120,
    parameter int unsigned FALL_FRAMES    = 60,
    parameter int unsigned SHOW_FRAMES    = 90,
    parameter int unsigned OVER_FRAMES    = 300,
    parameter logic [15:0] SCORE_STEP     = 16'h0500
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        start_btn,
    input  logic        shot,
    input  logic        hit,
    input  logic        duck_escaped,
    output logic [2:0]  state,
    output logic        shot_flash,
    output logic [2:0]  num_shots,
    output logic [3:0]  ducks_left,
    output logic [3:0]  hits,
    output logic [15:0] score_bcd
);

    typedef enum logic [2:0] {
        START     = 3'b000,
        DOG_INTRO = 3'b001,
        DUCK_FLY  = 3'b010,
        GAME_OVER = 3'b011,
        DUCK_FALL = 3'b100,
        DOG_SHOW  = 3'b101,
        DOG_LAUGH = 3'b110,
        ILLEGAL   = 3'b111
    } phase_e;

    // Last frame count of each timed phase: exit on the tick that
    // sees this value, giving exactly N ticks in the phase.
    localparam logic [8:0] INTRO_LAST = 9'(INTRO_FRAMES - 1);
    localparam logic [8:0] FALL_LAST  = 9'(FALL_FRAMES - 1);
    localparam logic [8:0] SHOW_LAST  = 9'(SHOW_FRAMES - 1);
    localparam logic [8:0] OVER_LAST  = 9'(OVER_FRAMES - 1);
    localparam logic [2:0] SHOTS_INIT = 3'(SHOTS_PER_DUCK);
    localparam logic [3:0] DUCKS_INIT = 4'(DUCKS_PER_GAME);

    phase_e      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        flash_q, flash_d;
    logic [2:0]  shots_q, shots_d;
    logic [3:0]  ducks_q, ducks_d;
    logic [3:0]  hits_q, hits_d;
    logic [15:0] score_q, score_d;
    logic        btn_q, btn_d;

    logic start_edge;
    logic valid_shot;
    logic intro_done;
    logic fall_done;
    logic show_done;
    logic over_done;

    assign intro_done = frame_tick && (cnt_q == INTRO_LAST);
    assign fall_done  = frame_tick && (cnt_q == FALL_LAST);
    assign show_done  = frame_tick && (cnt_q == SHOW_LAST);
    assign over_done  = frame_tick && (cnt_q == OVER_LAST);

    // Digit-wise BCD add; a carry out of the top digit pins the
    // display at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_sat_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [15:0] r;
        logic        c;
        logic [4:0]  s;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        if (c) begin
            r = 16'h9999;
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flash_d    = flash_q;
        shots_d    = shots_q;
        ducks_d    = ducks_q;
        hits_d     = hits_q;
        score_d    = score_q;
        btn_d      = start_btn;
        start_edge = start_btn & ~btn_q;
        valid_shot = 1'b0;

        case (state_q)
            START: begin
                if (start_edge) begin
                    state_d = DOG_INTRO;
                    score_d = '0;
                    hits_d  = '0;
                    ducks_d = DUCKS_INIT;
                end
            end
            DOG_INTRO: begin
                if (intro_done) begin
                    state_d = DUCK_FLY;
                    shots_d = SHOTS_INIT;
                end
            end
            DUCK_FLY: begin
                valid_shot = shot && (shots_q != 3'd0);
                if (valid_shot) begin
                    shots_d = shots_q - 3'd1;
                end
                // A hit outranks an escape on the same cycle.
                if (valid_shot && hit) begin
                    state_d = DUCK_FALL;
                    hits_d  = (hits_q == 4'hF) ? hits_q : hits_q + 4'd1;
                    score_d = bcd_sat_add(score_q, SCORE_STEP);
                end else if (duck_escaped || (shots_q == 3'd0)) begin
                    state_d = DOG_LAUGH;
                end
            end
            DUCK_FALL: begin
                if (fall_done) begin
                    state_d = DOG_SHOW;
                end
            end
            DOG_SHOW, DOG_LAUGH: begin
                if (show_done) begin
                    ducks_d = ducks_q - 4'd1;
                    if (ducks_q == 4'd1) begin
                        state_d = GAME_OVER;
                    end else begin
                        state_d = DUCK_FLY;
                        shots_d = SHOTS_INIT;
                    end
                end
            end
            GAME_OVER: begin
                if (over_done || start_edge) begin
                    state_d = START;
                end
            end
            default: begin
                state_d = START;
            end
        endcase

        // Set wins over the frame-tick clear.
        if (valid_shot) begin
            flash_d = 1'b1;
        end else if (frame_tick) begin
            flash_d = 1'b0;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (frame_tick) begin
            cnt_d = cnt_q + 9'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= START;
            cnt_q   <= '0;
            flash_q <= 1'b0;
            shots_q <= '0;
            ducks_q <= '0;
            hits_q  <= '0;
            score_q <= '0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
            shots_q <= shots_d;
            ducks_q <= ducks_d;
            hits_q  <= hits_d;
            score_q <= score_d;
            btn_q   <= btn_d;
        end
    end

    assign state      = state_q;
    assign shot_flash = flash_q;
    assign num_shots  = shots_q;
    assign ducks_left = ducks_q;
    assign hits       = hits_q;
    assign score_bcd  = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus a
// randomized full game against a behavioural game model.
module tb_game_sequencer;

    logic clk;
    logic rst_n;

    logic        frame_tick, start_btn, shot, hit, duck_escaped;
    logic [2:0]  state, num_shots;
    logic        shot_flash;
    logic [3:0]  ducks_left, hits;
    logic [15:0] score_bcd;

    logic        b_tick, b_btn, b_shot, b_hit, b_esc;
    logic [2:0]  b_state, b_shots;
    logic        b_flash;
    logic [3:0]  b_ducks, b_hits;
    logic [15:0] b_score;

    int n_chk;
    int n_fail;
    bit btn_lvl;

    // Behavioural model of the default-parameter game.
    int m_state, m_ticks, m_shots, m_ducks, m_hits, m_score;
    bit m_flash, m_prev;

    game_sequencer dut (
        .Clk(clk), .Reset_n(rst_n), .frame_tick(frame_tick),
        .start_btn(start_btn), .shot(shot), .hit(hit),
        .duck_escaped(duck_escaped), .state(state),
        .shot_flash(shot_flash), .num_shots(num_shots),
        .ducks_left(ducks_left), .hits(hits), .score_bcd(score_bcd)
    );

    game_sequencer #(
        .SHOTS_PER_DUCK(3), .DUCKS_PER_GAME(3), .INTRO_FRAMES(4),
        .FALL_FRAMES(3), .SHOW_FRAMES(2), .OVER_FRAMES(5),
        .SCORE_STEP(16'h4900)
    ) dut2 (
        .Clk(clk), .Reset_n(rst_n), .frame_tick(b_tick),
        .start_btn(b_btn), .shot(b_shot), .hit(b_hit),
        .duck_escaped(b_esc), .state(b_state),
        .shot_flash(b_flash), .num_shots(b_shots),
        .ducks_left(b_ducks), .hits(b_hits), .score_bcd(b_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10),
                4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_ticks = 0; m_shots = 0; m_ducks = 0;
        m_hits = 0; m_score = 0; m_flash = 0; m_prev = 0;
    endtask

    // Game rules: phase names are their output codes, score is decimal.
    task automatic model_step(input bit ft, input bit sb, input bit sh,
                              input bit ht, input bit es);
        int nxt;
        bit pressed, fired;
        pressed = sb && !m_prev;
        m_prev = sb;
        nxt = m_state;
        fired = 0;
        case (m_state)
            0: if (pressed) begin
                nxt = 1; m_score = 0; m_hits = 0; m_ducks = 10;
            end
            1: if (ft && m_ticks + 1 == 120) begin
                nxt = 2; m_shots = 3;
            end
            2: begin
                fired = sh && m_shots > 0;
                if (fired && ht) begin
                    nxt = 4;
                    if (m_hits < 15) m_hits++;
                    m_score = m_score + 500;
                    if (m_score > 9999) m_score = 9999;
                end else if (es || m_shots == 0) begin
                    nxt = 6;
                end
                if (fired) m_shots--;
            end
            4: if (ft && m_ticks + 1 == 60) nxt = 5;
            5, 6: if (ft && m_ticks + 1 == 90) begin
                m_ducks--;
                if (m_ducks == 0) nxt = 3;
                else begin nxt = 2; m_shots = 3; end
            end
            3: if ((ft && m_ticks + 1 == 300) || pressed) nxt = 0;
            default: nxt = 0;
        endcase
        if (fired) m_flash = 1;
        else if (ft) m_flash = 0;
        if (nxt != m_state) m_ticks = 0;
        else if (ft) m_ticks++;
        m_state = nxt;
    endtask

    task automatic cyc(input bit ft, input bit sh, input bit ht,
                       input bit es);
        frame_tick = ft; shot = sh; hit = ht; duck_escaped = es;
        start_btn = btn_lvl;
        @(posedge clk);
        model_step(ft, btn_lvl, sh, ht, es);
        @(negedge clk);
        frame_tick = 0; shot = 0; hit = 0; duck_escaped = 0;
    endtask

    task automatic tk(input int n);
        repeat (n) cyc(1, 0, 0, 0);
    endtask

    task automatic cyc2(input bit ft, input bit sh, input bit ht,
                        input bit es);
        b_tick = ft; b_shot = sh; b_hit = ht; b_esc = es;
        @(posedge clk);
        @(negedge clk);
        b_tick = 0; b_shot = 0; b_hit = 0; b_esc = 0;
    endtask

    task automatic tk2(input int n);
        repeat (n) cyc2(1, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({state, shot_flash, num_shots, ducks_left, hits, score_bcd}
            !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got st=%0d fl=%0d sh=%0d dk=%0d ht=%0d sc=%h want all 0",
                     state, shot_flash, num_shots, ducks_left, hits, score_bcd);
        end
        rst_n = 1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_start_intro();
        btn_lvl = 1;
        cyc(0, 0, 0, 0);
        n_chk++;
        if (state !== 3'd1 || ducks_left !== 4'd10 || score_bcd !== 16'h0)
        begin
            n_fail++;
            $display("FAIL start_edge: got st=%0d dk=%0d sc=%h want 1 10 0000",
                     state, ducks_left, score_bcd);
        end
        repeat (119) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
        n_chk++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL intro_119: got st=%0d want 1", state);
        end
        tk(1);
        n_chk++;
        if (state !== 3'd2 || num_shots !== 3'd3) begin
            n_fail++;
            $display("FAIL intro_done: got st=%0d sh=%0d want 2 3",
                     state, num_shots);
        end
        btn_lvl = 0;
    endtask

    task automatic test_hit();
        cyc(0, 1, 1, 0);
        n_chk++;
        if (state !== 3'd4 || hits !== 4'd1 || score_bcd !== 16'h0500 ||
            shot_flash !== 1'b1 || num_shots !== 3'd2) begin
            n_fail++;
            $display("FAIL hit: got st=%0d ht=%0d sc=%h fl=%0d sh=%0d want 4 1 0500 1 2",
                     state, hits, score_bcd, shot_flash, num_shots);
        end
        cyc(0, 0, 0, 0);
        n_chk++;
        if (shot_flash !== 1'b1) begin
            n_fail++;
            $display("FAIL flash_hold: got %0d want 1", shot_flash);
        end
        tk(1);
        n_chk++;
        if (shot_flash !== 1'b0) begin
            n_fail++;
            $display("FAIL flash_clear: got %0d want 0", shot_flash);
        end
        tk(58);
        n_chk++;
        if (state !== 3'd4) begin
            n_fail++;
            $display("FAIL fall_59: got st=%0d want 4", state);
        end
        tk(1);
        n_chk++;
        if (state !== 3'd5) begin
            n_fail++;
            $display("FAIL fall_done: got st=%0d want 5", state);
        end
        tk(90);
        n_chk++;
        if (state !== 3'd2 || ducks_left !== 4'd9 || num_shots !== 3'd3)
        begin
            n_fail++;
            $display("FAIL show_done: got st=%0d dk=%0d sh=%0d want 2 9 3",
                     state, ducks_left, num_shots);
        end
    endtask

    task automatic test_miss();
        for (int i = 2; i >= 0; i--) begin
            cyc(0, 1, 0, 0);
            n_chk++;
            if (num_shots !== 3'(i) || shot_flash !== 1'b1 ||
                state !== 3'd2) begin
                n_fail++;
                $display("FAIL miss_shot: got sh=%0d fl=%0d st=%0d want %0d 1 2",
                         num_shots, shot_flash, state, i);
            end
        end
        // Fourth shot with a tick: an accepted shot would keep flash high.
        cyc(1, 1, 0, 0);
        n_chk++;
        if (state !== 3'd6 || shot_flash !== 1'b0 || num_shots !== 3'd0)
        begin
            n_fail++;
            $display("FAIL fourth_shot: got st=%0d fl=%0d sh=%0d want 6 0 0",
                     state, shot_flash, num_shots);
        end
        tk(89);
        n_chk++;
        if (state !== 3'd6) begin
            n_fail++;
            $display("FAIL laugh_89: got st=%0d want 6", state);
        end
        tk(1);
        n_chk++;
        if (state !== 3'd2 || ducks_left !== 4'd8) begin
            n_fail++;
            $display("FAIL laugh_done: got st=%0d dk=%0d want 2 8",
                     state, ducks_left);
        end
    endtask

    task automatic test_priority();
        cyc(0, 0, 1, 0);
        n_chk++;
        if (state !== 3'd2 || hits !== 4'd1 || num_shots !== 3'd3) begin
            n_fail++;
            $display("FAIL hit_no_shot: got st=%0d ht=%0d sh=%0d want 2 1 3",
                     state, hits, num_shots);
        end
        cyc(0, 1, 1, 1);
        n_chk++;
        if (state !== 3'd4 || hits !== 4'd2 || score_bcd !== 16'h1000) begin
            n_fail++;
            $display("FAIL hit_vs_escape: got st=%0d ht=%0d sc=%h want 4 2 1000",
                     state, hits, score_bcd);
        end
        tk(150);
        cyc(0, 0, 0, 1);
        n_chk++;
        if (state !== 3'd6) begin
            n_fail++;
            $display("FAIL escape: got st=%0d want 6", state);
        end
        tk(90);
        n_chk++;
        if (state !== 3'd2 || ducks_left !== 4'd6) begin
            n_fail++;
            $display("FAIL escape_done: got st=%0d dk=%0d want 2 6",
                     state, ducks_left);
        end
    endtask

    task automatic test_reset_midfly();
        #2 rst_n = 0;
        #1;
        n_chk++;
        if (state !== 3'd0 || score_bcd !== 16'h0 || num_shots !== 3'd0 ||
            ducks_left !== 4'd0 || hits !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: got st=%0d sc=%h sh=%0d dk=%0d ht=%0d want 0",
                     state, score_bcd, num_shots, ducks_left, hits);
        end
        btn_lvl = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_random_game();
        bit ft, sh, ht, es, seen_over, done;
        btn_lvl = 1;
        cyc(0, 0, 0, 0);
        seen_over = 0;
        done = 0;
        for (int i = 0; i < 40000 && !done; i++) begin
            if ($urandom_range(199) == 0) btn_lvl = ~btn_lvl;
            ft = ($urandom_range(2) == 0);
            sh = ($urandom_range(7) == 0);
            ht = 1'($urandom_range(1));
            es = ($urandom_range(63) == 0);
            cyc(ft, sh, ht, es);
            n_chk++;
            if (state !== m_state[2:0] || shot_flash !== m_flash ||
                num_shots !== m_shots[2:0] || ducks_left !== m_ducks[3:0] ||
                hits !== m_hits[3:0] || score_bcd !== to_bcd(m_score)) begin
                n_fail++;
                $display("FAIL random_cycle %0d: got st=%0d fl=%0d sh=%0d dk=%0d ht=%0d sc=%h want %0d %0d %0d %0d %0d %h",
                         i, state, shot_flash, num_shots, ducks_left, hits,
                         score_bcd, m_state, m_flash, m_shots, m_ducks,
                         m_hits, to_bcd(m_score));
            end
            if (m_state == 3) seen_over = 1;
            if (seen_over && m_state == 0) done = 1;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL random_timeout: game did not finish, st=%0d", state);
        end
        btn_lvl = 0;
        start_btn = 0;
    endtask

    task automatic test_saturate_over();
        b_btn = 1;
        cyc2(0, 0, 0, 0);
        tk2(4);
        n_chk++;
        if (b_state !== 3'd2 || b_ducks !== 4'd3) begin
            n_fail++;
            $display("FAIL small_intro: got st=%0d dk=%0d want 2 3",
                     b_state, b_ducks);
        end
        cyc2(0, 1, 1, 0);
        tk2(5);
        cyc2(0, 1, 1, 0);
        n_chk++;
        if (b_score !== 16'h9800) begin
            n_fail++;
            $display("FAIL score_9800: got %h want 9800", b_score);
        end
        tk2(5);
        cyc2(0, 1, 1, 0);
        n_chk++;
        if (b_score !== 16'h9999 || b_hits !== 4'd3) begin
            n_fail++;
            $display("FAIL score_saturate: got sc=%h ht=%0d want 9999 3",
                     b_score, b_hits);
        end
        tk2(5);
        n_chk++;
        if (b_state !== 3'd3 || b_ducks !== 4'd0) begin
            n_fail++;
            $display("FAIL game_over: got st=%0d dk=%0d want 3 0",
                     b_state, b_ducks);
        end
        tk2(4);
        n_chk++;
        if (b_state !== 3'd3) begin
            n_fail++;
            $display("FAIL over_4: got st=%0d want 3", b_state);
        end
        tk2(1);
        n_chk++;
        if (b_state !== 3'd0 || b_score !== 16'h9999) begin
            n_fail++;
            $display("FAIL over_done: got st=%0d sc=%h want 0 9999",
                     b_state, b_score);
        end
        b_btn = 0;
        cyc2(0, 0, 0, 0);
        b_btn = 1;
        cyc2(0, 0, 0, 0);
        n_chk++;
        if (b_state !== 3'd1 || b_score !== 16'h0 || b_hits !== 4'd0) begin
            n_fail++;
            $display("FAIL restart: got st=%0d sc=%h ht=%0d want 1 0000 0",
                     b_state, b_score, b_hits);
        end
        tk2(4);
        repeat (3) begin cyc2(0, 0, 0, 1); tk2(2); end
        n_chk++;
        if (b_state !== 3'd3) begin
            n_fail++;
            $display("FAIL escape_game_over: got st=%0d want 3", b_state);
        end
        b_btn = 0;
        cyc2(0, 0, 0, 0);
        b_btn = 1;
        cyc2(0, 0, 0, 0);
        repeat (5) cyc2(0, 0, 0, 0);
        n_chk++;
        if (b_state !== 3'd0) begin
            n_fail++;
            $display("FAIL held_key: got st=%0d want 0", b_state);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        btn_lvl = 0;
        frame_tick = 0; start_btn = 0; shot = 0; hit = 0; duck_escaped = 0;
        b_tick = 0; b_btn = 0; b_shot = 0; b_hit = 0; b_esc = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_start_intro();
        test_hit();
        test_miss();
        test_priority();
        test_reset_midfly();
        test_random_game();
        test_saturate_over();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
